// File: rtl/mul_arb_pkg.sv
// Shared types, defaults and the round-robin pick helper for the multiplier arbiter.
package mul_arb_pkg;

  localparam int MUL_ARB_WIDTH = 4;
  localparam int MUL_ARB_NREQ  = 4;
  localparam int MAX_NREQ      = 16;
  localparam int PTRW          = 4;

  // ARB_BUSY is only reachable when the operand register stage is built in.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_RESULT = 2'd1,
    ARB_BUSY   = 2'd2
  } mul_arb_state_e;

  // First valid lane scanning ptr, ptr+1, ... modulo n. Returns 0 when nothing is valid;
  // callers qualify the result with |valid. ptr must be below n.
  function automatic logic [PTRW-1:0] rr_pick(input logic [MAX_NREQ-1:0] valid,
                                               input logic [PTRW-1:0]     ptr,
                                               input int unsigned         n);
    logic [PTRW-1:0] idx;
    logic [PTRW:0]   j;
    logic            found;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      j = {1'b0, ptr} + (PTRW+1)'(k);
      if (j >= (PTRW+1)'(n)) j = j - (PTRW+1)'(n);
      if (!found && (k < int'(n))) begin
        if (valid[j[PTRW-1:0]]) begin
          idx   = j[PTRW-1:0];
          found = 1'b1;
        end
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/mul_core.sv
// Combinational unsigned WIDTHxWIDTH multiplier built from shifted partial products.
module mul_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p
);

  // Accumulate a<<i for every set bit of b; the full 2*WIDTH result is kept.
  always_comb begin
    p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) p = p + ((2*WIDTH)'(a) << i);
    end
  end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one mul_core between NREQ requesters, with a tagged
// valid/ready result channel. Define MUL_ARB_PIPE_EN to add an operand register stage
// (2-cycle latency, one transaction in flight).
//
// state      | meaning
// ARB_IDLE   | no result held, free to accept
// ARB_RESULT | res_* valid, waiting for res_ready
// ARB_BUSY   | operands latched, product lands next edge (MUL_ARB_PIPE_EN only)
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = MUL_ARB_WIDTH,
  parameter int NREQ  = MUL_ARB_NREQ
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  output logic [2*WIDTH-1:0]       res_data,
  output logic [$clog2(NREQ)-1:0]  res_id,
  input  logic                     res_ready
);

  localparam int IDW = $clog2(NREQ);

  mul_arb_state_e     state, state_nxt;
  logic [IDW-1:0]     rr_ptr, grant;
  logic               busy, can_accept, accept;
  logic [WIDTH-1:0]   sel_a, sel_b, mul_a, mul_b;
  logic [2*WIDTH-1:0] product;

  // Grant index and the granted lane's operands.
  always_comb begin
    grant = IDW'(rr_pick(MAX_NREQ'(req_valid), PTRW'(rr_ptr), NREQ));
    sel_a = req_a[grant*WIDTH +: WIDTH];
    sel_b = req_b[grant*WIDTH +: WIDTH];
  end

  assign res_valid = (state == ARB_RESULT);

`ifdef MUL_ARB_PIPE_EN
  logic [WIDTH-1:0] op_a, op_b;
  logic [IDW-1:0]   op_id;

  assign busy = (state == ARB_BUSY);

  // Operand stage: capture the accepted lane so the multiply happens next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a  <= '0;
      op_b  <= '0;
      op_id <= '0;
    end else if (accept) begin
      op_a  <= sel_a;
      op_b  <= sel_b;
      op_id <= grant;
    end
  end

  assign mul_a = op_a;
  assign mul_b = op_b;
`else
  assign busy  = 1'b0;
  assign mul_a = sel_a;
  assign mul_b = sel_b;
`endif

  assign can_accept = !busy && (!res_valid || res_ready);
  // Gated by rst so no lane sees an accept while reset is held.
  assign accept     = can_accept && (|req_valid) && !rst;

  // One-hot accept toward the granted lane.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  mul_core #(.WIDTH(WIDTH)) u_mul_core (
    .a (mul_a),
    .b (mul_b),
    .p (product)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
`ifdef MUL_ARB_PIPE_EN
      ARB_IDLE:   if (accept) state_nxt = ARB_BUSY;
      ARB_BUSY:   state_nxt = ARB_RESULT;
      ARB_RESULT: if (res_ready) state_nxt = accept ? ARB_BUSY : ARB_IDLE;
`else
      ARB_IDLE:   if (accept) state_nxt = ARB_RESULT;
      ARB_RESULT: if (res_ready) state_nxt = accept ? ARB_RESULT : ARB_IDLE;
`endif
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  // Result registers and round-robin pointer; res_* hold when no new product lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data <= '0;
      res_id   <= '0;
      rr_ptr   <= '0;
    end else begin
      if (accept) rr_ptr <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
`ifdef MUL_ARB_PIPE_EN
      if (state == ARB_BUSY) begin
        res_data <= product;
        res_id   <= op_id;
      end
`else
      if (accept) begin
        res_data <= product;
        res_id   <= grant;
      end
`endif
    end
  end

endmodule
